// File: rtl/nonce_sweep_scheduler.sv
// nonce_sweep_scheduler
// Drives a SHA-256 core through a nonce range. Each nonce is spliced into the
// latched header block, issued to the core with a one-cycle flag, and the
// returned hash is compared against the latched difficulty target. The sweep
// stops on the first winning hash, at the end of the range, or when the core
// fails to answer within TIMEOUT cycles.

module nonce_sweep_scheduler #(
    parameter int CHUNK_W   = 512,
    parameter int HASH_W    = 256,
    parameter int NONCE_MSB = 511,
    parameter int TIMEOUT   = 1023
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [CHUNK_W-1:0] header_chunk,
    input  logic [31:0]        nonce_first,
    input  logic [31:0]        nonce_last,
    input  logic [HASH_W-1:0]  target,
    input  logic               hash_done,
    input  logic [HASH_W-1:0]  HASH,
    output logic [CHUNK_W-1:0] chunk,
    output logic               flag,
    output logic               busy,
    output logic               found,
    output logic               exhausted,
    output logic               timeout_err,
    output logic [31:0]        NONCE_OUT,
    output logic [31:0]        hash_count
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_CHECK = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    state_t             state_r;
    state_t             next_state_s;

    logic [CHUNK_W-1:0] header_r;
    logic [31:0]        nonce_r;
    logic [31:0]        last_r;
    logic [HASH_W-1:0]  target_r;
    logic [HASH_W-1:0]  hash_r;
    logic [CNT_W-1:0]   wait_cnt_r;

    logic [CHUNK_W-1:0] chunk_r;
    logic               flag_r;
    logic               busy_r;
    logic               found_r;
    logic               exhausted_r;
    logic               timeout_r;
    logic [31:0]        nonce_out_r;
    logic [31:0]        hash_count_r;

    logic               flag_nxt_s;
    logic               busy_nxt_s;
    logic               start_ok_s;
    logic               win_s;
    logic               last_s;
    logic               expired_s;

    // Overwrite the nonce field of a header block, keeping every other bit.
    function automatic logic [CHUNK_W-1:0] splice_nonce(
        input logic [CHUNK_W-1:0] hdr,
        input logic [31:0]        nonce
    );
        logic [CHUNK_W-1:0] blk;
        blk = hdr;
        blk[NONCE_MSB -: 32] = nonce;
        return blk;
    endfunction

    assign start_ok_s = ((state_r == ST_IDLE) || (state_r == ST_DONE)) && start && !abort;
    assign win_s      = (hash_r < target_r);
    assign last_s     = (nonce_r == last_r);
    assign expired_s  = (wait_cnt_r == CNT_LAST);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode; abort overrides everything, including a same-cycle start.
    always_comb begin
        next_state_s = state_r;
        if (abort) begin
            next_state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        next_state_s = ST_LOAD;
                    end else begin
                        next_state_s = state_r;
                    end
                end
                ST_LOAD:  next_state_s = ST_ISSUE;
                ST_ISSUE: next_state_s = ST_WAIT;
                ST_WAIT: begin
                    if (hash_done) begin
                        next_state_s = ST_CHECK;
                    end else if (expired_s) begin
                        next_state_s = ST_DONE;
                    end else begin
                        next_state_s = ST_WAIT;
                    end
                end
                ST_CHECK: begin
                    if (win_s || last_s) begin
                        next_state_s = ST_DONE;
                    end else begin
                        next_state_s = ST_LOAD;
                    end
                end
                default:  next_state_s = ST_IDLE;
            endcase
        end
    end

    // Output decode from the upcoming state so flag/busy can be registered without extra latency.
    always_comb begin
        flag_nxt_s = 1'b0;
        busy_nxt_s = 1'b0;
        case (next_state_s)
            ST_ISSUE: begin
                flag_nxt_s = 1'b1;
                busy_nxt_s = 1'b1;
            end
            ST_LOAD, ST_WAIT, ST_CHECK: begin
                flag_nxt_s = 1'b0;
                busy_nxt_s = 1'b1;
            end
            default: begin
                flag_nxt_s = 1'b0;
                busy_nxt_s = 1'b0;
            end
        endcase
    end

    // Registered flag and busy outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            flag_r <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            flag_r <= flag_nxt_s;
            busy_r <= busy_nxt_s;
        end
    end

    // Sweep datapath: latched job, current nonce, wait counter and sticky status.
    always_ff @(posedge clock) begin
        if (reset) begin
            header_r     <= {CHUNK_W{1'b0}};
            nonce_r      <= 32'd0;
            last_r       <= 32'd0;
            target_r     <= {HASH_W{1'b0}};
            hash_r       <= {HASH_W{1'b0}};
            wait_cnt_r   <= {CNT_W{1'b0}};
            chunk_r      <= {CHUNK_W{1'b0}};
            found_r      <= 1'b0;
            exhausted_r  <= 1'b0;
            timeout_r    <= 1'b0;
            nonce_out_r  <= 32'd0;
            hash_count_r <= 32'd0;
        end else if (abort) begin
            // hash_count and NONCE_OUT deliberately keep their values.
            found_r     <= 1'b0;
            exhausted_r <= 1'b0;
            timeout_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start_ok_s) begin
                        header_r     <= header_chunk;
                        nonce_r      <= nonce_first;
                        last_r       <= nonce_last;
                        target_r     <= target;
                        found_r      <= 1'b0;
                        exhausted_r  <= 1'b0;
                        timeout_r    <= 1'b0;
                        hash_count_r <= 32'd0;
                    end else begin
                        nonce_r <= nonce_r;
                    end
                end
                ST_LOAD: begin
                    chunk_r <= splice_nonce(header_r, nonce_r);
                end
                ST_ISSUE: begin
                    wait_cnt_r <= {CNT_W{1'b0}};
                end
                ST_WAIT: begin
                    // A response in the final wait cycle still counts.
                    if (hash_done) begin
                        hash_r <= HASH;
                    end else if (expired_s) begin
                        timeout_r   <= 1'b1;
                        nonce_out_r <= nonce_r;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_CHECK: begin
                    if (hash_count_r != 32'hFFFF_FFFF) begin
                        hash_count_r <= hash_count_r + 32'd1;
                    end else begin
                        hash_count_r <= hash_count_r;
                    end
                    // A win on the final nonce reports found, not exhausted.
                    if (win_s) begin
                        found_r     <= 1'b1;
                        nonce_out_r <= nonce_r;
                    end else if (last_s) begin
                        exhausted_r <= 1'b1;
                        nonce_out_r <= nonce_r;
                    end else begin
                        nonce_r <= nonce_r + 32'd1;
                    end
                end
                default: begin
                    nonce_r <= nonce_r;
                end
            endcase
        end
    end

    assign chunk       = chunk_r;
    assign flag        = flag_r;
    assign busy        = busy_r;
    assign found       = found_r;
    assign exhausted   = exhausted_r;
    assign timeout_err = timeout_r;
    assign NONCE_OUT   = nonce_out_r;
    assign hash_count  = hash_count_r;

endmodule

// File: tb/tb_nonce_sweep_scheduler.sv
// Directed bench for nonce_sweep_scheduler. The bench plays the SHA-256 core
// by hand: it watches for flag, checks the spliced chunk and answers with a
// chosen hash. Timeout is shortened to 16 cycles.

module tb_nonce_sweep_scheduler;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic         abort;
    logic [511:0] header_chunk;
    logic [31:0]  nonce_first;
    logic [31:0]  nonce_last;
    logic [255:0] target;
    logic         hash_done;
    logic [255:0] HASH;
    logic [511:0] chunk;
    logic         flag;
    logic         busy;
    logic         found;
    logic         exhausted;
    logic         timeout_err;
    logic [31:0]  NONCE_OUT;
    logic [31:0]  hash_count;

    int vectors     = 0;
    int miscompares = 0;

    nonce_sweep_scheduler #(
        .CHUNK_W  (512),
        .HASH_W   (256),
        .NONCE_MSB(511),
        .TIMEOUT  (16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .header_chunk(header_chunk),
        .nonce_first (nonce_first),
        .nonce_last  (nonce_last),
        .target      (target),
        .hash_done   (hash_done),
        .HASH        (HASH),
        .chunk       (chunk),
        .flag        (flag),
        .busy        (busy),
        .found       (found),
        .exhausted   (exhausted),
        .timeout_err (timeout_err),
        .NONCE_OUT   (NONCE_OUT),
        .hash_count  (hash_count)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check512(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] exp_chunk(input logic [511:0] hdr, input logic [31:0] n);
        logic [511:0] c;
        c = hdr;
        c[511:480] = n;
        return c;
    endfunction

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) begin
            b[i*32 +: 32] = $urandom;
        end
        return b;
    endfunction

    // Apply a job and hold start for one sampling edge; afterwards the DUT sits in LOAD.
    task automatic start_sweep(input logic [511:0] hdr, input logic [31:0] first,
                               input logic [31:0] last, input logic [255:0] tgt);
        header_chunk = hdr;
        nonce_first  = first;
        nonce_last   = last;
        target       = tgt;
        start        = 1'b1;
        tick();
        start        = 1'b0;
    endtask

    // Bounded wait for the flag pulse; n returns the number of cycles waited.
    task automatic wait_flag(input int max_cycles, output int n);
        n = 0;
        while (flag !== 1'b1 && n < max_cycles) begin
            tick();
            n++;
        end
        check1("flag_seen", flag, 1'b1);
    endtask

    // Core answer, presented for one edge while the DUT is in WAIT.
    task automatic respond(input logic [255:0] h);
        hash_done = 1'b1;
        HASH      = h;
        tick();
        hash_done = 1'b0;
        HASH      = 256'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [511:0] hdr;
        logic [31:0]  exp_n [3];
        int           n;
        logic         flag_seen;

        reset        = 1'b1;
        start        = 1'b0;
        abort        = 1'b0;
        header_chunk = 512'd0;
        nonce_first  = 32'd0;
        nonce_last   = 32'd0;
        target       = 256'd0;
        hash_done    = 1'b0;
        HASH         = 256'd0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Reset state
        check512("rst_chunk", chunk, 512'd0);
        check1("rst_flag", flag, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_found", found, 1'b0);
        check1("rst_exh", exhausted, 1'b0);
        check1("rst_tmo", timeout_err, 1'b0);
        check32("rst_nonce_out", NONCE_OUT, 32'd0);
        check32("rst_count", hash_count, 32'd0);

        // 1) Single nonce, immediate win, flag two cycles after start
        hdr = rand_block();
        start_sweep(hdr, 32'd5, 32'd5, {256{1'b1}});
        check1("t1_busy_load", busy, 1'b1);
        check1("t1_flag_load", flag, 1'b0);
        tick();
        check1("t1_flag_issue", flag, 1'b1);
        check512("t1_chunk", chunk, exp_chunk(hdr, 32'd5));
        tick();
        check1("t1_flag_wait", flag, 1'b0);
        check1("t1_busy_wait", busy, 1'b1);
        respond(256'd0);
        check1("t1_found_check", found, 1'b0);
        tick();
        check1("t1_found", found, 1'b1);
        check1("t1_exh", exhausted, 1'b0);
        check32("t1_nonce_out", NONCE_OUT, 32'd5);
        check32("t1_count", hash_count, 32'd1);
        check1("t1_busy_done", busy, 1'b0);

        // 2) Four nonces, nothing wins
        hdr = rand_block();
        start_sweep(hdr, 32'h10, 32'h13, 256'd0);
        check1("t2_found_clr", found, 1'b0);
        check32("t2_count_clr", hash_count, 32'd0);
        for (int k = 0; k < 4; k++) begin
            wait_flag(8, n);
            check32("t2_flag_lat", n, (k == 0) ? 32'd1 : 32'd2);
            check512("t2_chunk", chunk, exp_chunk(hdr, 32'h10 + k));
            tick();
            respond(256'd1);
        end
        tick();
        check1("t2_exh", exhausted, 1'b1);
        check1("t2_found", found, 1'b0);
        check32("t2_count", hash_count, 32'd4);
        check32("t2_nonce_out", NONCE_OUT, 32'h13);
        check1("t2_busy", busy, 1'b0);

        // 3) Wrap-around range, only nonce 0 wins
        exp_n[0] = 32'hFFFF_FFFE;
        exp_n[1] = 32'hFFFF_FFFF;
        exp_n[2] = 32'h0000_0000;
        hdr = rand_block();
        start_sweep(hdr, 32'hFFFF_FFFE, 32'h1, 256'd1);
        for (int k = 0; k < 3; k++) begin
            wait_flag(8, n);
            check32("t3_nonce", chunk[511:480], exp_n[k]);
            tick();
            respond((exp_n[k] == 32'd0) ? 256'd0 : 256'd5);
        end
        tick();
        check1("t3_found", found, 1'b1);
        check1("t3_exh", exhausted, 1'b0);
        check32("t3_nonce_out", NONCE_OUT, 32'd0);
        check32("t3_count", hash_count, 32'd3);
        flag_seen = 1'b0;
        repeat (4) begin
            tick();
            flag_seen = flag_seen | flag;
        end
        check1("t3_no_flag", flag_seen, 1'b0);

        // 4) Core never answers: timeout after 16 WAIT cycles
        hdr = rand_block();
        start_sweep(hdr, 32'd7, 32'd9, 256'd0);
        tick();
        tick();
        flag_seen = 1'b0;
        repeat (15) begin
            tick();
            flag_seen = flag_seen | flag;
        end
        check1("t4_busy_w15", busy, 1'b1);
        check1("t4_tmo_early", timeout_err, 1'b0);
        check1("t4_no_reflag", flag_seen, 1'b0);
        tick();
        check1("t4_tmo", timeout_err, 1'b1);
        check1("t4_busy", busy, 1'b0);
        check32("t4_nonce_out", NONCE_OUT, 32'd7);
        check1("t4_found", found, 1'b0);

        // Abort in DONE clears status, keeps NONCE_OUT
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check1("t4_abort_tmo", timeout_err, 1'b0);
        check32("t4_abort_nonce", NONCE_OUT, 32'd7);

        // 5) Abort with start in WAIT; late hash_done ignored
        hdr = rand_block();
        start_sweep(hdr, 32'h20, 32'h30, 256'd0);
        tick();
        tick();
        respond(256'd1);
        tick();
        tick();
        check1("t5_flag2", flag, 1'b1);
        tick();
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check1("t5_busy", busy, 1'b0);
        check1("t5_flag", flag, 1'b0);
        check1("t5_found", found, 1'b0);
        check1("t5_exh", exhausted, 1'b0);
        check1("t5_tmo", timeout_err, 1'b0);
        check32("t5_count_hold", hash_count, 32'd1);
        check32("t5_nonce_hold", NONCE_OUT, 32'd7);
        respond(256'd0);
        tick();
        check1("t5_late_found", found, 1'b0);
        check1("t5_late_busy", busy, 1'b0);
        check32("t5_late_count", hash_count, 32'd1);

        // 6) Reset in CHECK, then a fresh sweep
        hdr = rand_block();
        start_sweep(hdr, 32'h40, 32'h50, 256'd0);
        tick();
        tick();
        respond(256'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check512("t6_chunk", chunk, 512'd0);
        check1("t6_busy", busy, 1'b0);
        check1("t6_flag", flag, 1'b0);
        check32("t6_count", hash_count, 32'd0);
        check32("t6_nonce_out", NONCE_OUT, 32'd0);
        flag_seen = 1'b0;
        repeat (4) begin
            tick();
            flag_seen = flag_seen | flag;
        end
        check1("t6_no_flag", flag_seen, 1'b0);
        hdr = rand_block();
        start_sweep(hdr, 32'h99, 32'h99, {256{1'b1}});
        wait_flag(8, n);
        check512("t6_chunk2", chunk, exp_chunk(hdr, 32'h99));
        tick();
        respond(256'd0);
        tick();
        check1("t6_found", found, 1'b1);
        check32("t6_nonce_out2", NONCE_OUT, 32'h99);
        check32("t6_count2", hash_count, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
